// File: rtl/imm_pkg.sv
// Shared definitions for the instruction encoder and the immediate generator:
// immediate-format selector, the canonical NOP word and per-format immediate limits.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_sel_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Inclusive signed limits; B and J additionally require an even value
    localparam int signed IS_MIN = -2048;
    localparam int signed IS_MAX = 2047;
    localparam int signed B_MIN  = -4096;
    localparam int signed B_MAX  = 4094;
    localparam int signed J_MIN  = -1048576;
    localparam int signed J_MAX  = 1048574;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: extracts the sign-extended immediate of an RV32 instruction.
// Only built when ENC_SELFCHECK_EN is defined, where the encoder uses it to
// re-decode its own output.
`ifdef ENC_SELFCHECK_EN
module imm_gen
    import imm_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [2:0]  imm_sel,
    output logic [31:0] imm
);

    // Reassemble the scattered immediate bits for each format
    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule
`endif

// File: rtl/imm_range_chk.sv
// Combinational range/alignment check of an immediate against its instruction format.
// Unassigned selector codes are always reported as errors.
module imm_range_chk
    import imm_pkg::*;
(
    input  logic [2:0]         imm_sel,
    input  logic signed [31:0] imm,
    output logic               err
);

    // Flag immediates that cannot be represented in the selected format
    always_comb begin
        err = 1'b0;
        case (imm_sel)
            IMM_I, IMM_S: err = (imm < IS_MIN) || (imm > IS_MAX);
            IMM_B:        err = (imm < B_MIN) || (imm > B_MAX) || imm[0];
            IMM_U:        err = |imm[11:0];
            IMM_J:        err = (imm < J_MIN) || (imm > J_MAX) || imm[0];
            default:      err = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32 instruction encoder: packs fields plus an immediate into I/S/B/U/J words and
// streams them, with byte addresses, into program memory through a two-stage
// valid/ready pipeline. Words with an unencodable immediate become NOPs.
// Optional feature ENC_SELFCHECK_EN: re-decode each packed word and report
// disagreement with the original immediate on chk_fail.
module instr_encoder
    import imm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         imm_sel,
    input  logic [6:0]         opcode,
    input  logic [4:0]         rd,
    input  logic [2:0]         funct3,
    input  logic [4:0]         rs1,
    input  logic [4:0]         rs2,
    input  logic signed [31:0] imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_addr,
    output logic               out_err,
    output logic [7:0]         err_cnt,
`ifdef ENC_SELFCHECK_EN
    output logic               chk_fail,
`endif
    output logic               wrap
);

    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [31:0] pack_word(
        input logic [2:0]         sel,
        input logic [6:0]         op,
        input logic [4:0]         rd_f,
        input logic [2:0]         f3,
        input logic [4:0]         rs1_f,
        input logic [4:0]         rs2_f,
        input logic signed [31:0] im
    );
        logic [31:0] w;
        case (sel)
            IMM_I:   w = {im[11:0], rs1_f, f3, rd_f, op};
            IMM_S:   w = {im[11:5], rs2_f, rs1_f, f3, im[4:0], op};
            IMM_B:   w = {im[12], im[10:5], rs2_f, rs1_f, f3, im[4:1], im[11], op};
            IMM_U:   w = {im[31:12], rd_f, op};
            IMM_J:   w = {im[20], im[10:1], im[11], im[19:12], rd_f, op};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

    logic               vld_p1;
    logic [2:0]         sel_p1;
    logic [6:0]         op_p1;
    logic [4:0]         rd_p1;
    logic [2:0]         f3_p1;
    logic [4:0]         rs1_p1;
    logic [4:0]         rs2_p1;
    logic signed [31:0] imm_p1;
    logic               err_p1;
    logic               err_c;
    logic [31:0]        raw_p1;
    logic               s2_move;
    logic               in_fire;
    logic               out_fire;

    imm_range_chk u_range (
        .imm_sel (imm_sel),
        .imm     (imm),
        .err     (err_c)
    );

    assign s2_move  = !out_valid || out_ready;
    assign in_ready = !vld_p1 || s2_move;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign raw_p1   = pack_word(sel_p1, op_p1, rd_p1, f3_p1, rs1_p1, rs2_p1, imm_p1);

    // ---- stage 1: capture fields and range verdict ----
    // Stage-1 occupancy; clear drops the word held here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (clear) begin
            vld_p1 <= 1'b0;
        end else if (in_ready) begin
            vld_p1 <= in_valid;
        end
    end

    // Stage-1 payload, loaded on every input handshake
    always_ff @(posedge clk) begin
        if (in_fire) begin
            sel_p1 <= imm_sel;
            op_p1  <= opcode;
            rd_p1  <= rd;
            f3_p1  <= funct3;
            rs1_p1 <= rs1;
            rs2_p1 <= rs2;
            imm_p1 <= imm;
            err_p1 <= err_c;
        end
    end

    // ---- stage 2: packed word, address counter and error bookkeeping ----
    // Output register, address/wrap tracking and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= '0;
            out_err   <= 1'b0;
            out_addr  <= BASE_ADDR;
            err_cnt   <= '0;
            wrap      <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_addr  <= BASE_ADDR;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (out_fire) begin
                if (out_addr == LAST_ADDR) begin
                    out_addr <= BASE_ADDR;
                    wrap     <= 1'b1;
                end else begin
                    out_addr <= out_addr + 32'd4;
                end
                if (out_err)
                    err_cnt <= sat_inc8(err_cnt);
            end
            if (s2_move) begin
                out_valid <= vld_p1;
                if (vld_p1) begin
                    out_instr <= err_p1 ? NOP_INSTR : raw_p1;
                    out_err   <= err_p1;
                end
            end
        end
    end

`ifdef ENC_SELFCHECK_EN
    logic [31:0] dec_imm;

    imm_gen u_dec (
        .instr   (raw_p1),
        .imm_sel (sel_p1),
        .imm     (dec_imm)
    );

    // Round-trip verdict travels with the word into stage 2; NOP-replaced words never flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_fail <= 1'b0;
        end else if (clear) begin
            chk_fail <= 1'b0;
        end else if (s2_move && vld_p1) begin
            chk_fail <= !err_p1 && (dec_imm != imm_p1);
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized stream,
// scored against a transaction-level model of the encoder.
module tb_instr_encoder;

    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          DEPTH = 4;
    localparam logic [31:0] LAST  = BASE + 32'(4 * (DEPTH - 1));
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, clear, in_valid, in_ready, out_valid, out_ready, out_err, wrap;
    logic [2:0]  imm_sel, funct3;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, out_instr, out_addr;
    logic [7:0]  err_cnt;
`ifdef ENC_SELFCHECK_EN
    logic        chk_fail;
`endif

    instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .imm_sel   (imm_sel),
        .opcode    (opcode),
        .rd        (rd),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
`ifdef ENC_SELFCHECK_EN
        .chk_fail  (chk_fail),
`endif
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } stim_t;

    typedef struct {
        logic [31:0] instr;
        logic        err;
    } exp_t;

    stim_t       sq[$];
    exp_t        mq[$];
    logic [31:0] seen_addr[$];
    bit          m_s2;
    logic [31:0] m_addr;
    logic [7:0]  m_ecnt;
    logic        m_wrap;
    bit          d_out_ready, d_clear;
    int          n_checks, n_errors, wrap_seen;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic stim_t mk(input logic [2:0] sel, input logic [6:0] op, input logic [4:0] rdv,
                                 input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [31:0] iv);
        stim_t s;
        s.sel = sel; s.op = op; s.rd = rdv; s.f3 = f3; s.rs1 = r1; s.rs2 = r2; s.imm = iv;
        return s;
    endfunction

    // Encodability straight from the format's numeric range and alignment
    function automatic bit ref_err(input stim_t s);
        int signed v;
        v = $signed(s.imm);
        case (s.sel)
            3'd0, 3'd1: return (v < -2048) || (v > 2047);
            3'd2:       return (v < -4096) || (v > 4094) || (v % 2 != 0);
            3'd3:       return (s.imm % 32'd4096) != 32'd0;
            3'd4:       return (v < -1048576) || (v > 1048574) || (v % 2 != 0);
            default:    return 1'b1;
        endcase
    endfunction

    // Field placement by shift-and-mask arithmetic
    function automatic logic [31:0] ref_word(input stim_t s);
        logic [31:0] u, op, rdv, f3, r1, r2, regs;
        u = s.imm; op = 32'(s.op); rdv = 32'(s.rd); f3 = 32'(s.f3);
        r1 = 32'(s.rs1); r2 = 32'(s.rs2);
        regs = (r1 << 15) | (f3 << 12) | op;
        case (s.sel)
            3'd0: return ((u & 32'hFFF) << 20) | regs | (rdv << 7);
            3'd1: return (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | regs | ((u & 32'h1F) << 7);
            3'd2: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20) | regs
                         | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
            3'd3: return (u & 32'hFFFF_F000) | (rdv << 7) | op;
            3'd4: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                         | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | (rdv << 7) | op;
            default: return NOP;
        endcase
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        int    r, lo, hi;
        r = int'($urandom_range(0, 15));
        s.sel = (r < 14) ? 3'(r % 5) : 3'(5 + r % 3);
        s.op = 7'($urandom); s.rd = 5'($urandom); s.f3 = 3'($urandom);
        s.rs1 = 5'($urandom); s.rs2 = 5'($urandom);
        case (s.sel)
            3'd0, 3'd1: begin lo = -2048;    hi = 2047;    end
            3'd2:       begin lo = -4096;    hi = 4094;    end
            3'd4:       begin lo = -1048576; hi = 1048574; end
            default:    begin lo = -16;      hi = 16;      end
        endcase
        r = int'($urandom_range(0, 9));
        if (s.sel == 3'd3) begin
            s.imm = $urandom;
            if (r < 7) s.imm = s.imm & 32'hFFFF_F000;
        end else begin
            case (r)
                0:       s.imm = 32'(lo);
                1:       s.imm = 32'(hi);
                2:       s.imm = 32'(lo - 1);
                3:       s.imm = 32'(hi + 1);
                4:       s.imm = $urandom;
                default: begin
                    s.imm = 32'(lo + int'($urandom_range(0, 32'(hi - lo))));
                    if (s.sel == 3'd2 || s.sel == 3'd4) s.imm = s.imm & ~32'h1;
                end
            endcase
        end
        return s;
    endfunction

    task automatic model_reset();
        mq.delete(); m_s2 = 0; m_addr = BASE; m_ecnt = 8'd0; m_wrap = 1'b0;
    endtask

    // One clock: drive at the falling edge, predict the rising edge, check at the next falling edge
    task automatic cycle();
        stim_t s;
        exp_t  e, dropped;
        bit    exp_ov, ir_exp, ofire, ifire;
        if (sq.size() > 0) begin
            s = sq[0];
            in_valid = 1'b1; imm_sel = s.sel; opcode = s.op; rd = s.rd;
            funct3 = s.f3; rs1 = s.rs1; rs2 = s.rs2; imm = s.imm;
        end else begin
            in_valid = 1'b0;
        end
        out_ready = d_out_ready;
        clear     = d_clear;
        #1;
        exp_ov = (mq.size() > 0) && m_s2;
        ir_exp = (mq.size() < 2) || d_out_ready;
        check_eq("in_ready", 32'(in_ready), 32'(ir_exp));
        ifire = in_valid && ir_exp;
        ofire = exp_ov && d_out_ready;
        if (ifire) s = sq.pop_front();
        if (d_clear) begin
            mq.delete(); m_s2 = 0; m_addr = BASE; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (ofire) begin
                seen_addr.push_back(out_addr);
                m_wrap = (m_addr == LAST);
                m_addr = m_wrap ? BASE : m_addr + 32'd4;
                if (mq[0].err) m_ecnt = (m_ecnt == 8'hFF) ? 8'hFF : m_ecnt + 8'd1;
                dropped = mq.pop_front();
                m_s2 = 0;
            end
            if (!m_s2) m_s2 = (mq.size() > 0);
            if (ifire) begin
                e.err   = ref_err(s);
                e.instr = e.err ? NOP : ref_word(s);
                mq.push_back(e);
            end
        end
        @(negedge clk);
        exp_ov = (mq.size() > 0) && m_s2;
        check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov && out_valid) begin
            check_eq("out_instr", out_instr, mq[0].instr);
            check_eq("out_err", 32'(out_err), 32'(mq[0].err));
`ifdef ENC_SELFCHECK_EN
            check_eq("chk_fail", 32'(chk_fail), 32'd0);
`endif
        end
        check_eq("out_addr", out_addr, m_addr);
        check_eq("err_cnt", 32'(err_cnt), 32'(m_ecnt));
        check_eq("wrap", 32'(wrap), 32'(m_wrap));
        if (wrap) wrap_seen++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_pulse();
        d_clear = 1'b1; cycle(); d_clear = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check_eq({tag, "_out_instr"}, out_instr, 32'd0);
        check_eq({tag, "_out_addr"}, out_addr, BASE);
        check_eq({tag, "_out_err"}, 32'(out_err), 32'd0);
        check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        check_eq({tag, "_wrap"}, 32'(wrap), 32'd0);
    endtask

    initial begin
        int sent;
        n_checks = 0; n_errors = 0; wrap_seen = 0;
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        imm_sel = '0; opcode = '0; rd = '0; funct3 = '0; rs1 = '0; rs2 = '0; imm = '0;
        d_out_ready = 1'b1; d_clear = 1'b0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check_reset_state("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);

        // I-type, latency
        sq.push_back(mk(3'd0, 7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5));
        cycle();
        check_eq("lat_not_yet", 32'(out_valid), 32'd0);
        cycle();
        check_eq("i_valid", 32'(out_valid), 32'd1);
        check_eq("i_word", out_instr, 32'h0050_0093);
        check_eq("i_addr", out_addr, 32'h0);

        // B-type negative offset
        sq.push_back(mk(3'd2, 7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, -32'sd8));
        run(2);
        check_eq("b_word", out_instr, 32'hFE20_8CE3);
        check_eq("b_err", 32'(out_err), 32'd0);
        check_eq("b_addr", out_addr, 32'h4);

        // J-type odd offset, then illegal selector
        sq.push_back(mk(3'd4, 7'b1101111, 5'd1, 3'd0, 5'd0, 5'd0, 32'd3));
        run(2);
        check_eq("j_odd_word", out_instr, NOP);
        check_eq("j_odd_err", 32'(out_err), 32'd1);
        cycle();
        check_eq("j_odd_cnt", 32'(err_cnt), 32'd1);
        sq.push_back(mk(3'd7, 7'b0010011, 5'd3, 3'd0, 5'd4, 5'd5, 32'd0));
        run(3);
        check_eq("badsel_cnt", 32'(err_cnt), 32'd2);

        // U-type
        sq.push_back(mk(3'd3, 7'b0110111, 5'd5, 3'd0, 5'd0, 5'd0, 32'h1234_5000));
        run(2);
        check_eq("u_word", out_instr, 32'h1234_52B7);
        run(3);

        // Backpressure: three offered while output is blocked
        clear_pulse();
        seen_addr.delete();
        d_out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            sq.push_back(mk(3'd0, 7'b0010011, 5'(i + 1), 3'd0, 5'd2, 5'd0, 32'(i * 7)));
        run(5);
        check_eq("bp_in_ready", 32'(in_ready), 32'd0);
        d_out_ready = 1'b1;
        run(6);
        check_eq("bp_count", 32'(seen_addr.size()), 32'd3);
        for (int i = 0; i < 3 && i < seen_addr.size(); i++)
            check_eq("bp_addr", seen_addr[i], 32'(4 * i));

        // Address wrap over a DEPTH=4 window
        clear_pulse();
        seen_addr.delete();
        wrap_seen = 0;
        for (int i = 0; i < 5; i++)
            sq.push_back(mk(3'd1, 7'b0100011, 5'd0, 3'd2, 5'd3, 5'(i), 32'(i * 4)));
        run(10);
        check_eq("wrap_count", 32'(seen_addr.size()), 32'd5);
        for (int i = 0; i < 5 && i < seen_addr.size(); i++)
            check_eq("wrap_addr", seen_addr[i], 32'((4 * i) % 16));
        check_eq("wrap_pulses", 32'(wrap_seen), 32'd1);

        // Clear mid-stream keeps the error count
        for (int i = 0; i < 4; i++)
            sq.push_back(mk(3'd0, 7'b0010011, 5'd9, 3'd0, 5'd1, 5'd0, 32'(i)));
        run(3);
        clear_pulse();
        check_eq("clr_valid", 32'(out_valid), 32'd0);
        check_eq("clr_addr", out_addr, BASE);
        check_eq("clr_cnt", 32'(err_cnt), 32'd2);
        run(6);

        // Asynchronous reset with words in flight
        for (int i = 0; i < 3; i++) sq.push_back(rand_stim());
        d_out_ready = 1'b0;
        run(2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("mid_rst");
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        sq.delete();
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        d_out_ready = 1'b1;

        // Randomized stream with backpressure and occasional clears
        sent = 0;
        while (sent < 1500) begin
            if (sq.size() == 0 && $urandom_range(0, 3) != 0) begin
                sq.push_back(rand_stim());
                sent++;
            end
            d_out_ready = ($urandom_range(0, 3) != 0);
            d_clear     = ($urandom_range(0, 199) == 0);
            cycle();
        end
        d_clear = 1'b0;
        d_out_ready = 1'b1;
        run(6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
